// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared helpers for the Rijndael ShiftRows datapath.
//   nb_legal(nb)       : 1 when nb is a supported column count (4, 6 or 8)
//   shift_off(r, nb)   : left-rotate amount applied to state row r
//   byte_idx(row, col) : flat byte index k of a state element (k = 4*col + row)
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int ROWS = 4;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rows 2 and 3 rotate further for 256-bit blocks.
  function automatic int shift_off(input int r, input int nb);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      default: return (nb == 8) ? 4 : 3;
    endcase
  endfunction

  function automatic int byte_idx(input int row, input int col);
    return ROWS * col + row;
  endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// ---------------------------------------------------------------------------
// aes_shift_rows_perm
// Pure combinational ShiftRows / InvShiftRows byte permutation.
//   din  : input state, byte k = bits [8k+7:8k], row = k mod 4, col = k div 4
//   inv  : 0 = forward ShiftRows, 1 = InvShiftRows
//   dout : permuted state, same byte layout
// ---------------------------------------------------------------------------
module aes_shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] din,
  input  logic             inv,
  output logic [32*NB-1:0] dout
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("aes_shift_rows_perm: NB must be 4, 6 or 8");
  end

  // Every output byte is a fixed wire from one of two source bytes, so the
  // whole permutation reduces to a 2:1 mux per byte selected by inv.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S     = shift_off(r, NB);
      localparam int K_OUT = byte_idx(r, c);
      localparam int K_FWD = byte_idx(r, (c + S) % NB);
      localparam int K_INV = byte_idx(r, (c - S + NB) % NB);

      assign dout[8*K_OUT +: 8] = inv ? din[8*K_INV +: 8] : din[8*K_FWD +: 8];
    end
  end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// aes_shift_rows_pipe
// ShiftRows stage with a 2-entry output FIFO and valid/ready handshakes.
// The permutation is applied before storage, so the buffer holds only the
// transformed state and its sideband tag.
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready = buffer not full)
//   in_data/in_inv/in_tag : state, direction select, sideband tag
//   out_valid/out_ready : output handshake
//   out_data/out_tag    : head entry of the buffer
//   occupancy           : number of buffered beats, 0..2
// ---------------------------------------------------------------------------
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic [1:0]         occupancy
);

  localparam int DW    = 32 * NB;
  localparam int DEPTH = 2;

  logic [DW-1:0]    perm_data;

  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] tag_d  [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic             push;
  logic             pop;

  aes_shift_rows_perm #(.NB(NB)) u_perm (
    .din  (in_data),
    .inv  (in_inv),
    .dout (perm_data)
  );

  // Both handshake outputs depend only on the registered count, which keeps
  // out_ready from reaching in_ready combinationally.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];
  assign occupancy = count_q;

  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      data_d[wr_ptr_q] = perm_data;
      tag_d[wr_ptr_q]  = in_tag;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous push and pop leaves the count unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_aes_shift_rows_pipe
// Self-checking bench for aes_shift_rows_pipe. Three instances (NB = 4, 6, 8)
// share clock, reset and handshake controls; each has its own data input so
// forward results can be fed back for the inverse round trip.
// ---------------------------------------------------------------------------
module tb_aes_shift_rows_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   in_tag = '0;
  logic [127:0] in4 = '0;
  logic [191:0] in6 = '0;
  logic [255:0] in8 = '0;

  logic         rdy4, rdy6, rdy8;
  logic         ov4, ov6, ov8;
  logic [127:0] od4;
  logic [191:0] od6;
  logic [255:0] od8;
  logic [3:0]   ot4, ot6, ot8;
  logic [1:0]   occ4, occ6, occ8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in4), .in_inv(in_inv), .in_tag(in_tag), .out_valid(ov4),
    .out_ready(out_ready), .out_data(od4), .out_tag(ot4), .occupancy(occ4)
  );

  aes_shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6),
    .in_data(in6), .in_inv(in_inv), .in_tag(in_tag), .out_valid(ov6),
    .out_ready(out_ready), .out_data(od6), .out_tag(ot6), .occupancy(occ6)
  );

  aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in8), .in_inv(in_inv), .in_tag(in_tag), .out_valid(ov8),
    .out_ready(out_ready), .out_data(od8), .out_tag(ot8), .occupancy(occ8)
  );

  // Reference model: unpack into a 4 x NB byte matrix, rotate each row by
  // its offset, repack. Bytes above 32*nb bits come back as zero.
  function automatic logic [255:0] ref_shift(input logic [255:0] d,
                                             input int nb, input bit inv);
    logic [7:0]   st [4][8];
    int           sh [4];
    int           src;
    logic [255:0] res;
    res   = '0;
    sh[0] = 0;
    sh[1] = 1;
    sh[2] = (nb == 8) ? 3 : 2;
    sh[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        res[8*(4*c+r) +: 8] = st[r][src];
      end
    return res;
  endfunction

  function automatic logic [255:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [255:0] d,
                               input logic inv, input logic [3:0] t);
    in_valid = v;
    in4      = d[127:0];
    in6      = d[191:0];
    in8      = d;
    in_inv   = inv;
    in_tag   = t;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [255:0] vec_in;
  logic [255:0] beat_a, beat_b, beat_c, orig;
  logic [3:0]   t;
  int           got;

  initial begin
    vec_in = 256'h0f0e0d0c0b0a09080706050403020100;

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    checkOutput("rst_out_valid", ov4, 0);
    checkOutput("rst_in_ready", rdy4, 1);
    checkOutput("rst_occupancy", occ4, 0);
    checkOutput("rst_out_data", od4, 0);
    checkOutput("rst_out_tag", ot4, 0);
    rst_n = 1'b1;
    step();

    // Known-answer forward beat.
    $display("[TB] known-answer vectors");
    out_ready = 1'b0;
    applyStimulus(1, vec_in, 0, 4'h5);
    step();
    applyStimulus(0, '0, 0, 4'h0);
    checkOutput("kat_fwd_valid", ov4, 1);
    checkOutput("kat_fwd_data", od4, 256'h0b06010c07020d08030e09040f0a0500);
    checkOutput("kat_fwd_tag", ot4, 4'h5);
    checkOutput("kat_fwd_occ", occ4, 1);
    out_ready = 1'b1;
    step();
    checkOutput("kat_fwd_drained", ov4, 0);

    // Known-answer inverse beat.
    applyStimulus(1, vec_in, 1, 4'ha);
    step();
    applyStimulus(0, '0, 0, 4'h0);
    checkOutput("kat_inv_data", od4, 256'h0306090c0f0205080b0e0104070a0d00);
    checkOutput("kat_inv_tag", ot4, 4'ha);
    step();
    checkOutput("kat_inv_drained", ov4, 0);

    // Backpressure: three beats offered, two accepted.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    beat_a = rand_state();
    beat_b = rand_state();
    beat_c = rand_state();
    applyStimulus(1, beat_a, 0, 4'h1);
    step();
    applyStimulus(1, beat_b, 1, 4'h2);
    step();
    applyStimulus(1, beat_c, 0, 4'h3);
    checkOutput("bp_in_ready_low", rdy4, 0);
    step();
    checkOutput("bp_occ_full", occ4, 2);
    checkOutput("bp_in_ready_still_low", rdy4, 0);
    checkOutput("bp_head_stable", od4, ref_shift(beat_a, 4, 0));
    checkOutput("bp_head_tag", ot4, 4'h1);
    out_ready = 1'b1;
    step();
    checkOutput("bp_drain_b", od4, ref_shift(beat_b, 4, 1));
    checkOutput("bp_drain_b_tag", ot4, 4'h2);
    checkOutput("bp_occ_one", occ4, 1);
    checkOutput("bp_in_ready_up", rdy4, 1);
    step();
    applyStimulus(0, '0, 0, 4'h0);
    checkOutput("bp_third_data", od4, ref_shift(beat_c, 4, 0));
    checkOutput("bp_third_tag", ot4, 4'h3);
    checkOutput("bp_third_occ", occ4, 1);
    step();
    checkOutput("bp_empty", ov4, 0);

    // Streaming at one beat per cycle.
    $display("[TB] streaming");
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      orig = rand_state();
      t    = 4'($urandom_range(0, 15));
      applyStimulus(1, orig, 1'($urandom_range(0, 1)), t);
      step();
      if (ov4) got++;
      checkOutput("stream_data", od4, ref_shift(orig, 4, in_inv));
      checkOutput("stream_tag", ot4, t);
      checkOutput("stream_occ", occ4, 1);
    end
    applyStimulus(0, '0, 0, 4'h0);
    step();
    checkOutput("stream_beats", got, 20);
    checkOutput("stream_empty", ov4, 0);

    // Reset with a full buffer.
    $display("[TB] mid-operation reset");
    out_ready = 1'b0;
    applyStimulus(1, rand_state(), 0, 4'h7);
    step();
    applyStimulus(1, rand_state(), 1, 4'h8);
    step();
    checkOutput("mrst_full", occ4, 2);
    rst_n = 1'b0;
    applyStimulus(1, rand_state(), 0, 4'h9);
    step();
    rst_n = 1'b1;
    applyStimulus(0, '0, 0, 4'h0);
    checkOutput("mrst_out_valid", ov4, 0);
    checkOutput("mrst_occ", occ4, 0);
    checkOutput("mrst_out_data", od4, 0);
    checkOutput("mrst_out_tag", ot4, 0);
    checkOutput("mrst_in_ready", rdy4, 1);

    // A beat offered during reset with room available must be discarded.
    rst_n = 1'b0;
    applyStimulus(1, rand_state(), 0, 4'hb);
    step();
    rst_n = 1'b1;
    applyStimulus(0, '0, 0, 4'h0);
    checkOutput("rst_drop_valid", ov4, 0);
    checkOutput("rst_drop_occ", occ4, 0);
    step();
    checkOutput("rst_drop_later", ov4, 0);

    // Round trip on all three widths.
    $display("[TB] round trip NB=4/6/8");
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      orig = rand_state();
      t    = 4'($urandom_range(0, 15));
      applyStimulus(1, orig, 0, t);
      step();
      checkOutput("rt4_fwd", od4, ref_shift(orig, 4, 0));
      checkOutput("rt6_fwd", od6, ref_shift(orig, 6, 0));
      checkOutput("rt8_fwd", od8, ref_shift(orig, 8, 0));
      in4    = od4;
      in6    = od6;
      in8    = od8;
      in_inv = 1'b1;
      step();
      checkOutput("rt4_back", od4, orig[127:0]);
      checkOutput("rt6_back", od6, orig[191:0]);
      checkOutput("rt8_back", od8, orig);
      checkOutput("rt4_tag", ot4, t);
      checkOutput("rt6_tag", ot6, t);
      checkOutput("rt8_tag", ot8, t);
      applyStimulus(0, '0, 0, 4'h0);
      step();
    end
    checkOutput("rt_empty4", ov4, 0);
    checkOutput("rt_empty8", ov8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_shift_rows_pipe.md
AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns (legal 4, 6, 8; Rijndael block = 32*NB bits).
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag passed through unchanged.
REQ-003 SHALL have port clk  input  1  meaning the single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  meaning the input beat is present.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts a beat this cycle.
REQ-007 SHALL have port in_data  input  32*NB  meaning the state; byte k = bits [8k+7:8k], row = k mod 4, col = k div 4.
REQ-008 SHALL have port in_inv  input  1  meaning 0 = ShiftRows, 1 = InvShiftRows, sampled per beat.
REQ-009 SHALL have port in_tag  input  TAG_W  meaning sideband, travels with the beat.
REQ-010 SHALL have port out_valid  output  1  meaning an output beat is present.
REQ-011 SHALL have port out_ready  input  1  meaning the consumer takes the beat.
REQ-012 SHALL have port out_data  output  32*NB  meaning the permuted state, same byte layout.
REQ-013 SHALL have port out_tag  output  TAG_W  meaning the tag of the output beat.
REQ-014 SHALL have port occupancy  output  2  meaning buffered beat count, 0..2.

Function
REQ-015 SHALL use row shift offsets s(0)=0, s(1)=1, s(2)=2, s(3)=3 for NB=4 or 6, and s=0,1,3,4 for NB=8.
REQ-016 SHALL produce, forward, out[r][c] = in[r][(c+s(r)) mod NB]; inverse, out[r][c] = in[r][(c-s(r)) mod NB].
REQ-017 SHALL apply the permutation before storage; the buffer holds transformed data, tag and nothing else.
REQ-018 SHALL hold a 2-entry FIFO (write pointer, read pointer, count); push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-019 SHALL drive in_ready = (count < 2), from registered state only, with no combinational path from out_ready.
REQ-020 SHALL drive out_valid = (count != 0) and drive out_data/out_tag from the head entry.
REQ-021 SHALL have a latency of 1 cycle: a beat pushed at edge N is visible on out_valid after edge N.
REQ-022 SHALL sustain 1 beat/cycle when out_ready is held high.
REQ-023 SHALL handle simultaneous push and pop at count=1 by leaving count unchanged and advancing both pointers.
REQ-024 SHALL let count reach 2 on a push without a pop at count=1; in_ready then falls on the next cycle.
REQ-025 SHALL keep out_data/out_tag stable while out_valid=1 and out_ready=0.
REQ-026 SHALL wrap pointers modulo 2.
REQ-027 SHALL ignore in_valid/in_data when in_ready=0, with no state change.
REQ-028 SHALL drive occupancy = count.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, set count, pointers and occupancy to 0, out_valid to 0, in_ready to 1, and storage to 0 (out_data=0, out_tag=0).
REQ-030 SHALL discard buffered beats on reset mid-operation; no beat accepted in the reset cycle appears at the output.

Structure
REQ-031 SHALL place the following in package aes_pkg: the legal-NB check, the shift-offset function s(r, NB) and the byte-index helper (row, col -> k).
REQ-032 SHALL isolate the pure combinational permutation in one sub-module, aes_shift_rows_perm (parameters NB; ports din, inv, dout).
REQ-033 SHALL raise an elaboration error for an illegal NB.

Verification
REQ-034 SHALL cover forward mode: NB=4, in_data=0x0f0e0d0c0b0a09080706050403020100, in_inv=0 -> out_data=0x0b06010c07020d08030e09040f0a0500 one cycle later.
REQ-035 SHALL cover inverse mode: the same input with in_inv=1 -> out_data=0x0306090c0f0205080b0e0104070a0d00.
REQ-036 SHALL cover round trip for NB=4, 6 and 8: a forward beat fed back with inv=1 -> the original data for 1000 random states with tags preserved.
REQ-037 SHALL cover backpressure: out_ready=0 and 3 beats offered -> 2 accepted, occupancy=2, in_ready=0; with out_ready=1 -> the beats drain in order, and the third is accepted after in_ready rises.
REQ-038 SHALL cover streaming: in_valid=out_ready=1 for 20 cycles -> 20 beats out, occupancy constant at 1, no bubbles.
REQ-039 SHALL cover mid-operation reset: rst_n=0 for one edge with occupancy=2 -> out_valid=0, occupancy=0, out_data=0, in_ready=1 on the next cycle.
